// File: rtl/align_grs_shifter.sv
// Multi-cycle alignment shifter: right-shifts a significand and produces guard/round/sticky.
// Latency: ceil(min(shift,WIDTH+2)/STEP) cycles after accept (0 for shift==0), then result held.
// Backpressure: result held stable in HOLD until out_ready; no new request accepted until then.
//
// Ports:
//   clock, reset_n        - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   - request handshake (number, shift)
//   out_valid / out_ready - result handshake (aligned, guard, round, sticky)
module align_grs_shifter #(
  parameter int WIDTH   = 64,
  parameter int SHIFT_W = 6,
  parameter int STEP    = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   number,
  input  logic [SHIFT_W-1:0] shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   aligned,
  output logic               guard,
  output logic               round,
  output logic               sticky
);

  // Extended datapath: {data, guard, round}.
  localparam int EW = WIDTH + 2;
  // Counter must hold WIDTH+2 even when SHIFT_W is narrower than that.
  localparam int CW = (SHIFT_W > $clog2(WIDTH + 3)) ? SHIFT_W : $clog2(WIDTH + 3);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t        state;
  logic [EW-1:0] ext;
  logic          sticky_q;
  logic [CW-1:0] remaining;

  logic [CW-1:0] shift_ext;
  logic [CW-1:0] req_amt;
  logic [CW-1:0] k;
  logic [EW-1:0] k_mask;

  always_comb begin
    shift_ext = CW'(shift);
    // Anything beyond WIDTH+2 pushes every bit into sticky; clamp to bound the loop.
    req_amt   = (shift_ext > CW'(EW)) ? CW'(EW) : shift_ext;
    k         = (remaining > CW'(STEP)) ? CW'(STEP) : remaining;
    // Low k bits of ext are the ones about to fall off the bottom this cycle.
    k_mask    = ~({EW{1'b1}} << k);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ext       <= '0;
      sticky_q  <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ext       <= {number, 2'b00};
            sticky_q  <= 1'b0;
            remaining <= req_amt;
            state     <= (req_amt == '0) ? HOLD : SHIFT;
          end
        end
        SHIFT: begin
          sticky_q  <= sticky_q | (|(ext & k_mask));
          ext       <= ext >> k;
          remaining <= remaining - k;
          if (remaining == k) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  // Intermediate shift values are hidden; outputs only show a finished result.
  assign aligned = out_valid ? ext[EW-1:2] : '0;
  assign guard   = out_valid & ext[1];
  assign round   = out_valid & ext[0];
  assign sticky  = out_valid & sticky_q;

endmodule

// File: tb/tb_align_grs_shifter.sv
// Bench for align_grs_shifter: two instances (STEP=8 and STEP=1) checked against
// an arithmetic model of number>>shift with guard/round/sticky.
// Directed cases first, then randomized transactions with random backpressure.
module tb_align_grs_shifter;

  logic        clk;
  logic        rst_n;
  logic        iv   [2];
  logic        ir   [2];
  logic [63:0] num  [2];
  logic [5:0]  sh   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [63:0] al   [2];
  logic        g    [2];
  logic        r    [2];
  logic        s    [2];

  int n_cmp;
  int n_err;

  align_grs_shifter #(.WIDTH(64), .SHIFT_W(6), .STEP(8)) dut8 (
    .clock(clk), .reset_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .number(num[0]), .shift(sh[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .aligned(al[0]), .guard(g[0]), .round(r[0]), .sticky(s[0])
  );

  align_grs_shifter #(.WIDTH(64), .SHIFT_W(6), .STEP(1)) dut1 (
    .clock(clk), .reset_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .number(num[1]), .shift(sh[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .aligned(al[1]), .guard(g[1]), .round(r[1]), .sticky(s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the original number.
  task automatic model(input logic [63:0] n, input int shamt,
                       output logic [63:0] a, output logic eg, output logic er,
                       output logic es);
    a  = (shamt >= 64) ? 64'd0 : (n >> shamt);
    eg = 1'b0;
    er = 1'b0;
    es = 1'b0;
    if (shamt >= 1 && shamt <= 64) eg = n[shamt-1];
    if (shamt >= 2 && shamt <= 65) er = n[shamt-2];
    if (shamt >= 3) begin
      if (shamt - 2 >= 64) es = |n;
      else                 es = |(n & ((64'd1 << (shamt - 2)) - 64'd1));
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic run_txn(input int sel, input logic [63:0] n, input int shamt,
                         input int hold_cycles);
    int          step;
    int          clamp;
    int          exp_lat;
    int          lat;
    logic [63:0] ea;
    logic        eg, er, es;
    logic [63:0] a0;
    logic        g0, r0, s0;
    step    = (sel == 0) ? 8 : 1;
    clamp   = (shamt > 66) ? 66 : shamt;
    exp_lat = (clamp + step - 1) / step;
    model(n, shamt, ea, eg, er, es);

    chk("in_ready_idle", 64'(ir[sel]), 64'd1);
    iv[sel]  = 1'b1;
    num[sel] = n;
    sh[sel]  = shamt[5:0];
    @(posedge clk); #1;
    iv[sel]  = 1'b0;
    num[sel] = rand64();
    sh[sel]  = 6'($urandom_range(0, 63));
    chk("in_ready_busy", 64'(ir[sel]), 64'd0);

    lat = 0;
    while (!ov[sel] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("aligned", al[sel], ea);
    chk("guard",   64'(g[sel]), 64'(eg));
    chk("round",   64'(r[sel]), 64'(er));
    chk("sticky",  64'(s[sel]), 64'(es));

    a0 = al[sel]; g0 = g[sel]; r0 = r[sel]; s0 = s[sel];
    for (int i = 0; i < hold_cycles; i++) begin
      iv[sel]  = 1'($urandom_range(0, 1));
      num[sel] = rand64();
      sh[sel]  = 6'($urandom_range(0, 63));
      @(posedge clk); #1;
      chk("hold_valid",   64'(ov[sel]), 64'd1);
      chk("hold_inready", 64'(ir[sel]), 64'd0);
      chk("hold_aligned", al[sel], a0);
      chk("hold_grs",     {61'd0, g[sel], r[sel], s[sel]}, {61'd0, g0, r0, s0});
    end
    iv[sel]   = 1'b0;
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    chk("release_valid",   64'(ov[sel]), 64'd0);
    chk("release_inready", 64'(ir[sel]), 64'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; num[i] = '0; sh[i] = '0; ordy[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(ov[0]), 64'd0);
    chk("reset_in_ready",  64'(ir[0]), 64'd1);
    chk("reset_aligned",   al[0], 64'd0);
    chk("reset_grs",       {61'd0, g[0], r[0], s[0]}, 64'd0);
    chk("reset_in_ready1", 64'(ir[1]), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_txn(0, 64'h8000_0000_0000_0001, 1, 0);
    run_txn(0, 64'h0000_0000_0000_00FF, 0, 2);
    run_txn(0, 64'h0000_0000_0000_00F1, 6, 0);
    run_txn(0, 64'h0000_0000_0000_00F0, 6, 0);
    run_txn(0, 64'hFFFF_FFFF_FFFF_FFFF, 63, 0);
    run_txn(1, 64'hFFFF_FFFF_FFFF_FFFF, 63, 0);
    run_txn(0, 64'h0123_4567_89AB_CDEF, 8, 5);
    run_txn(0, 64'h0123_4567_89AB_CDEF, 9, 0);
    run_txn(1, 64'h0000_0000_0000_0007, 3, 1);

    // out_ready outside HOLD must not disturb the idle block
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    chk("idle_ordy_inready", 64'(ir[0]), 64'd1);
    chk("idle_ordy_valid",   64'(ov[0]), 64'd0);

    // Reset in the middle of a shift aborts it immediately
    iv[0] = 1'b1; num[0] = rand64() | 64'h1; sh[0] = 6'd40;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid",   64'(ov[0]), 64'd0);
    chk("abort_aligned", al[0], 64'd0);
    chk("abort_inready", 64'(ir[0]), 64'd1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_pulse", 64'(ov[0]), 64'd0);
    end
    run_txn(0, 64'h0000_0000_0000_0001, 2, 0);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      logic [63:0] rn;
      int          rs;
      rn = rand64();
      if ($urandom_range(0, 3) == 0) rn = rn >> $urandom_range(0, 63);
      rs = $urandom_range(0, 63);
      run_txn(0, rn, rs, $urandom_range(0, 3));
    end
    for (int i = 0; i < 10; i++) begin
      run_txn(1, rand64(), $urandom_range(0, 63), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
